// File: rtl/bitblade_mac_ctrl.sv
// Command sequencer and wide accumulator around a 4-lane 8-bit dot-product datapath.
// Optional build macro BITBLADE_MAC_SAT_EN: accumulator saturates instead of wrapping.
module bitblade_mac_ctrl #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_funct,
    input  logic [31:0] cmd_in0,
    input  logic [31:0] cmd_in1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_out,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    input  logic [17:0] dp_c,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [2:0] F_CLEAR    = 3'd0;
    localparam logic [2:0] F_MAC      = 3'd1;
    localparam logic [2:0] F_READ_ACC = 3'd2;
    localparam logic [2:0] F_READ_CNT = 3'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [17:0]        prod_q, prod_d;
    logic [31:0]        dp_a_q, dp_a_d;
    logic [31:0]        dp_b_q, dp_b_d;
    logic [31:0]        rsp_out_q, rsp_out_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   acc_next;
    logic [31:0]        acc_ext;
    logic [31:0]        acc_next_ext;
    logic [31:0]        cnt_ext;

    // One extra bit of sum exposes the carry used for saturation
    always_comb begin
        sum = {1'b0, acc_q} + {{(ACC_W + 1 - 18){1'b0}}, prod_q};
`ifdef BITBLADE_MAC_SAT_EN
        acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
        acc_ext               = '0;
        acc_ext[ACC_W-1:0]    = acc_q;
        acc_next_ext          = '0;
        acc_next_ext[ACC_W-1:0] = acc_next;
        cnt_ext               = '0;
        cnt_ext[CNT_W-1:0]    = cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        rsp_out_d   = rsp_out_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_funct)
                        F_MAC: begin
                            dp_a_d  = cmd_in0;
                            dp_b_d  = cmd_in1;
                            state_d = MUL;
                        end
                        F_CLEAR: begin
                            acc_d       = '0;
                            cnt_d       = '0;
                            rsp_out_d   = '0;
                            rsp_valid_d = 1'b1;
                            state_d     = RSP;
                        end
                        F_READ_ACC: begin
                            rsp_out_d   = acc_ext;
                            rsp_valid_d = 1'b1;
                            state_d     = RSP;
                        end
                        F_READ_CNT: begin
                            rsp_out_d   = cnt_ext;
                            rsp_valid_d = 1'b1;
                            state_d     = RSP;
                        end
                        default: begin
                            rsp_out_d   = '0;
                            rsp_valid_d = 1'b1;
                            state_d     = RSP;
                        end
                    endcase
                end
            end
            MUL: begin
                prod_d  = dp_c;
                state_d = ACC;
            end
            ACC: begin
                acc_d       = acc_next;
                cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                rsp_out_d   = acc_next_ext;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            rsp_out_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            rsp_out_q   <= rsp_out_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;

endmodule

// File: tb/tb_bitblade_mac_ctrl.sv
// Scoreboard bench for bitblade_mac_ctrl: driver pushes expected responses, monitor pops and compares.
// Uses ACC_W=18 so wrap/saturation is reachable, CNT_W=4 so count saturation is reachable.
module tb_bitblade_mac_ctrl;

    localparam int     ACC_W   = 18;
    localparam int     CNT_W   = 4;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
    localparam int     CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_funct;
    logic [31:0] cmd_in0;
    logic [31:0] cmd_in1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_out;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic [17:0] dp_c;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          hs;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          last_rsp_cyc = 0;
    int          rdy_mode = 0;
    longint      acc_m = 0;
    int          cnt_m = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    bitblade_mac_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_funct (cmd_funct),
        .cmd_in0   (cmd_in0),
        .cmd_in1   (cmd_in1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_c      (dp_c),
        .busy      (busy)
    );

    // Stand-in for the combinational dot-product unit
    function automatic logic [17:0] dot(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
        return 18'(s);
    endfunction

    assign dp_c = dot(dp_a, dp_b);

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Issues one command, updates the reference model on acceptance and queues the expected reply
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int     waited = 0;
        exp_t   e;
        longint p;
        cmd_funct = f;
        cmd_in0   = a;
        cmd_in1   = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 60) begin
            waited++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            checkOutput("cmd_accept_timeout", {31'b0, cmd_ready}, 32'd1);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            return;
        end
        e.hs  = cyc;
        e.lat = 1;
        case (f)
            3'd0: begin
                acc_m  = 0;
                cnt_m  = 0;
                e.data = 32'd0;
            end
            3'd1: begin
                p = longint'(dot(a, b));
                acc_m = acc_m + p;
`ifdef BITBLADE_MAC_SAT_EN
                if (acc_m > ACC_MAX) acc_m = ACC_MAX;
`else
                acc_m = acc_m % (ACC_MAX + 1);
`endif
                if (cnt_m < CNT_MAX) cnt_m++;
                e.data = 32'(acc_m);
                e.lat  = 3;
                last_a = a;
                last_b = b;
            end
            3'd2:    e.data = 32'(acc_m);
            3'd3:    e.data = 32'(cnt_m);
            default: e.data = 32'd0;
        endcase
        exp_q.push_back(e);
        last_hs = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        checkOutput("dp_a", dp_a, last_a);
        checkOutput("dp_b", dp_b, last_b);
    endtask

    // Response backpressure: 0 = always ready, 1 = random, 2 = held low
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1:       rsp_ready = 1'($urandom_range(0, 1));
                2:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: checks latency on the first valid cycle, data every valid cycle, pops on handshake
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    if (!prev_valid)
                        checkOutput("latency", 32'(cyc - exp_q[0].hs), 32'(exp_q[0].lat));
                    checkOutput("rsp_out", rsp_out, exp_q[0].data);
                    checkOutput("cmd_ready_in_rsp", {31'b0, cmd_ready}, 32'd0);
                    checkOutput("busy_in_rsp", {31'b0, busy}, 32'd1);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        last_rsp_cyc = cyc;
                    end
                end
                prev_valid = rsp_valid && !rsp_ready;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            waited++;
            @(posedge clk);
        end
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          ok;
        logic [2:0]  f;
        int          r;
        logic [31:0] a;
        logic [31:0] b;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_funct = 3'd0;
        cmd_in0   = '0;
        cmd_in1   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_out", rsp_out, 32'd0);
        checkOutput("rst_dp_a", dp_a, 32'd0);
        checkOutput("rst_dp_b", dp_b, 32'd0);
        @(posedge clk);
        #1;

        // Directed MAC / read sequence
        applyStimulus(3'd1, 32'h01020304, 32'h01010101);
        applyStimulus(3'd3, 32'h0, 32'h0);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(3'd2, 32'h0, 32'h0);
        applyStimulus(3'd0, 32'h0, 32'h0);
        applyStimulus(3'd3, 32'h0, 32'h0);

        // Wrap or saturate on repeated maximal products
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(3'd2, 32'h0, 32'h0);
        drain();

        // Backpressure with the next command held valid through the response
        rdy_mode = 2;
        applyStimulus(3'd1, 32'h11223344, 32'h55667788);
        fork
            applyStimulus(3'd2, 32'h0, 32'h0);
            begin
                ok = 0;
                for (int i = 0; i < 20 && !ok; i++) begin
                    @(negedge clk);
                    if (rsp_valid) ok = 1;
                end
                checkOutput("bp_rsp_rise", 32'(ok), 32'd1);
                repeat (5) @(posedge clk);
                rdy_mode = 0;
            end
        join
        checkOutput("accept_after_rsp", 32'(last_hs), 32'(last_rsp_cyc + 1));
        drain();

        // Reset pulsed while in MUL
        applyStimulus(3'd1, 32'hA0B0C0D0, 32'h01020304);
        rst_n = 1'b0;
        exp_q.delete();
        acc_m  = 0;
        cnt_m  = 0;
        last_a = '0;
        last_b = '0;
        #1;
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("midrst_dp_a", dp_a, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("postrst_busy", {31'b0, busy}, 32'd0);
        applyStimulus(3'd2, 32'h0, 32'h0);
        applyStimulus(3'd3, 32'h0, 32'h0);

        // Reserved funct leaves acc and cnt alone
        applyStimulus(3'd0, 32'h0, 32'h0);
        applyStimulus(3'd1, 32'h01020304, 32'h01010101);
        applyStimulus(3'd5, 32'hDEADBEEF, 32'hCAFEF00D);
        applyStimulus(3'd2, 32'h0, 32'h0);
        applyStimulus(3'd3, 32'h0, 32'h0);
        drain();

        // Randomized traffic with random backpressure
        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r < 10)      f = 3'd1;
            else if (r < 13) f = 3'd2;
            else if (r < 16) f = 3'd3;
            else if (r < 17) f = 3'd0;
            else             f = 3'(4 + $urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
            applyStimulus(f, a, b);
        end
        rdy_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
